// File: rtl/io_ring_pwr_seq_if.sv
// Control/status bundle between the IO-ring power sequencer and its environment.
// master drives the supply-good, request and config inputs; slave is the sequencer.
interface io_ring_pwr_seq_if #(
   parameter int CNT_W = 8
);
   logic             vddio_ok_i;
   logic             vdd_ok_i;
   logic             force_off_i;
   logic [CNT_W-1:0] cfg_dly_i;
   logic             err_clr_i;
   logic             pad_ret_o;
   logic             pad_ie_o;
   logic             pad_oe_en_o;
   logic [2:0]       seq_state_o;
   logic             seq_done_o;
   logic             seq_err_o;

   modport master (
      output vddio_ok_i, vdd_ok_i, force_off_i, cfg_dly_i, err_clr_i,
      input  pad_ret_o, pad_ie_o, pad_oe_en_o, seq_state_o, seq_done_o, seq_err_o
   );

   modport slave (
      input  vddio_ok_i, vdd_ok_i, force_off_i, cfg_dly_i, err_clr_i,
      output pad_ret_o, pad_ie_o, pad_oe_en_o, seq_state_o, seq_done_o, seq_err_o
   );
endinterface

// File: rtl/io_ring_pwr_seq.sv
// Always-on sequencer for the EG1D80V IO ring safe-state controls (retention,
// input enable, output enable): ordered power-up/down with per-step delays.
module io_ring_pwr_seq #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   io_ring_pwr_seq_if.slave bus
);

   typedef enum logic [2:0] {
      OFF    = 3'd0,
      UP_RET = 3'd1,
      UP_IE  = 3'd2,
      UP_OE  = 3'd3,
      ON     = 3'd4,
      DN_OE  = 3'd5,
      DN_IE  = 3'd6,
      DN_RET = 3'd7
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] vddio_sync_r;
   logic [SYNC_STAGES-1:0] vdd_sync_r;
   logic                   vddio_s;
   logic                   vdd_s;
   logic                   pwr_ok_s;
   logic                   abort_s;
   logic                   cnt_zero_s;

   state_e           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ret_r;
   logic             ie_r;
   logic             oe_r;
   logic             done_r;
   logic             err_r;

   // Supply-good synchronizers; both are asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vddio_sync_r <= {SYNC_STAGES{1'b0}};
         vdd_sync_r   <= {SYNC_STAGES{1'b0}};
      end else begin
         vddio_sync_r <= {vddio_sync_r[SYNC_STAGES-2:0], bus.vddio_ok_i};
         vdd_sync_r   <= {vdd_sync_r[SYNC_STAGES-2:0], bus.vdd_ok_i};
      end
   end

   assign vddio_s    = vddio_sync_r[SYNC_STAGES-1];
   assign vdd_s      = vdd_sync_r[SYNC_STAGES-1];
   assign pwr_ok_s   = vddio_s & vdd_s;
   assign abort_s    = ~vdd_s | bus.force_off_i;
   assign cnt_zero_s = (cnt_r == CNT_ZERO);

   // Sequencer FSM; VDDIO loss outranks everything, then aborts, then step completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= OFF;
         cnt_r   <= CNT_ZERO;
         ret_r   <= 1'b1;
         ie_r    <= 1'b0;
         oe_r    <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else if (!vddio_s && (state_r != OFF)) begin
         state_r <= OFF;
         cnt_r   <= CNT_ZERO;
         ret_r   <= 1'b1;
         ie_r    <= 1'b0;
         oe_r    <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b1;
      end else begin
         if (bus.err_clr_i) begin
            err_r <= 1'b0;
         end
         case (state_r)
            OFF: begin
               if (pwr_ok_s && !bus.force_off_i) begin
                  state_r <= UP_RET;
                  cnt_r   <= bus.cfg_dly_i;
               end
            end
            UP_RET, UP_IE, UP_OE, ON: begin
               // Output enable drops on the same edge the down path is entered.
               if (abort_s) begin
                  state_r <= DN_OE;
                  cnt_r   <= bus.cfg_dly_i;
                  oe_r    <= 1'b0;
                  done_r  <= 1'b0;
               end else if (state_r == ON) begin
                  done_r <= 1'b1;
               end else if (!cnt_zero_s) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end else begin
                  cnt_r <= bus.cfg_dly_i;
                  case (state_r)
                     UP_RET: begin
                        ret_r   <= 1'b0;
                        state_r <= UP_IE;
                     end
                     UP_IE: begin
                        ie_r    <= 1'b1;
                        state_r <= UP_OE;
                     end
                     default: begin
                        oe_r    <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ON;
                     end
                  endcase
               end
            end
            DN_OE, DN_IE, DN_RET: begin
               if (!cnt_zero_s) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end else begin
                  cnt_r <= bus.cfg_dly_i;
                  case (state_r)
                     DN_OE: begin
                        state_r <= DN_IE;
                     end
                     DN_IE: begin
                        ie_r    <= 1'b0;
                        state_r <= DN_RET;
                     end
                     default: begin
                        ret_r   <= 1'b1;
                        state_r <= OFF;
                     end
                  endcase
               end
            end
            default: begin
               state_r <= OFF;
               ret_r   <= 1'b1;
               ie_r    <= 1'b0;
               oe_r    <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pad_ret_o   = ret_r;
   assign bus.pad_ie_o    = ie_r;
   assign bus.pad_oe_en_o = oe_r;
   assign bus.seq_state_o = state_r;
   assign bus.seq_done_o  = done_r;
   assign bus.seq_err_o   = err_r;

endmodule
